// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage with multi-cycle data memory and MEM/WB register
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           synchronous reset, active-high
//   wb_en_in      write-back enable from EXE/MEM
//   mem_r_en      load request
//   mem_w_en      store request (wins over mem_r_en when both are set)
//   alu_res       ALU result, byte address for loads and stores
//   val_rm        store data
//   dst_in        destination register index
//   freeze        combinational stall request to upstream stages
//   wb_en_out     registered write-back enable
//   mem_read_out  registered write-back select (1 = memory data, 0 = ALU result)
//   alu_res_out   registered ALU result
//   mem_data_out  registered load data
//   dst_out       registered destination index
module mem_stage #(
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_en_in,
   input  logic                  mem_r_en,
   input  logic                  mem_w_en,
   input  logic [DATA_WIDTH-1:0] alu_res,
   input  logic [DATA_WIDTH-1:0] val_rm,
   input  logic [3:0]            dst_in,
   output logic                  freeze,
   output logic                  wb_en_out,
   output logic                  mem_read_out,
   output logic [DATA_WIDTH-1:0] alu_res_out,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [3:0]            dst_out
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                  state;
   logic [CW-1:0]           wait_cnt;
   logic                    req;
   logic                    is_load;
   logic [AW-1:0]           word_idx;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [DATA_WIDTH-1:0]   mem_array [MEM_DEPTH];

   assign req     = mem_r_en | mem_w_en;
   assign is_load = mem_r_en & ~mem_w_en;

   // Rebase to word 0, drop the byte offset, keep only the index bits so
   // addresses outside the window alias back into the array.
   assign word_idx = AW'((alu_res - DATA_WIDTH'(BASE_ADDR)) >> 2);

   assign rd_data = mem_array[word_idx];

   // DONE is the only cycle of an access in which upstream may advance.
   assign freeze = req & (state != DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state    <= ACCESS;
                  wait_cnt <= '0;
               end
            end
            ACCESS: begin
               wait_cnt <= wait_cnt + CW'(1);
               if (wait_cnt == CW'(WAIT_CYCLES - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // The write lands on the edge leaving DONE; a reset in flight never
   // reaches DONE, so an aborted store leaves the array untouched.
   always_ff @(posedge clk) begin
      if (!rst && (state == DONE) && mem_w_en) begin
         mem_array[word_idx] <= val_rm;
      end
   end

   // MEM/WB register: bubbles during a stall keep the data fields so only
   // the enables need to be cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_out    <= 1'b0;
         mem_read_out <= 1'b0;
         alu_res_out  <= '0;
         mem_data_out <= '0;
         dst_out      <= '0;
      end else if (freeze) begin
         wb_en_out    <= 1'b0;
         mem_read_out <= 1'b0;
      end else begin
         wb_en_out    <= wb_en_in;
         mem_read_out <= is_load;
         alu_res_out  <= alu_res;
         dst_out      <= dst_in;
         if (is_load && (state == DONE)) begin
            mem_data_out <= rd_data;
         end
      end
   end

endmodule
